muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/rv32m_pkg.sv | 34 +++
 rtl/muldiv_addsub.sv | 20 ++
 rtl/muldiv_unit.sv | 192 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
//   funct3_e : RV32M funct3 op codes
//   state_e  : muldiv_unit FSM encoding
//   op_a_signed / op_b_signed : operand signedness per op
package rv32m_pkg;

    typedef enum logic [2:0] {
        OpMul    = 3'b000,
        OpMulh   = 3'b001,
        OpMulhsu = 3'b010,
        OpMulhu  = 3'b011,
        OpDiv    = 3'b100,
        OpDivu   = 3'b101,
        OpRem    = 3'b110,
        OpRemu   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_e;

    // MUL only keeps the low word, so its signedness is irrelevant; treat it as signed.
    function automatic logic op_a_signed(funct3_e f);
        return (f == OpMul) || (f == OpMulh) || (f == OpMulhsu) || (f == OpDiv) || (f == OpRem);
    endfunction

    function automatic logic op_b_signed(funct3_e f);
        return (f == OpMul) || (f == OpMulh) || (f == OpDiv) || (f == OpRem);
    endfunction

endpackage

// File: rtl/muldiv_addsub.sv
// 33-bit adder/subtractor shared by the multiply and divide iterations.
//   a, b  : 33-bit operands
//   sub   : 1 = a - b, 0 = a + b
//   sum   : 33-bit result
//   carry : carry-out (for subtraction, 1 means a >= b, i.e. no borrow)
module muldiv_addsub (
    input  logic [32:0] a,
    input  logic [32:0] b,
    input  logic        sub,
    output logic [32:0] sum,
    output logic        carry
);

    logic [33:0] full;

    assign full  = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {33'd0, sub};
    assign sum   = full[32:0];
    assign carry = full[33];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring
// division on operand magnitudes, followed by a sign-fix cycle.
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : request handshake (funct3, op_a, op_b)
//   flush               : synchronous abort, returns to IDLE
//   out_valid/out_ready : result handshake, result held while out_valid
//   busy                : stall request, high whenever not IDLE
module muldiv_unit
    import rv32m_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  funct3,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    funct3_e     f3_q, f3_d;
    logic        sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [31:0] mag_a_q, mag_a_d, mag_b_q, mag_b_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] result_q, result_d;

    // Request decode on the raw inputs.
    funct3_e     f3_in;
    logic        accept, a_neg_in, b_neg_in, div_zero_in, div_ovf_in;
    logic [31:0] mag_a_in, mag_b_in;

    assign f3_in       = funct3_e'(funct3);
    assign accept      = in_valid && (state_q == IDLE) && !flush;
    assign a_neg_in    = op_a_signed(f3_in) && op_a[31];
    assign b_neg_in    = op_b_signed(f3_in) && op_b[31];
    assign mag_a_in    = a_neg_in ? -op_a : op_a;
    assign mag_b_in    = b_neg_in ? -op_b : op_b;
    assign div_zero_in = funct3[2] && (op_b == 32'd0);
    assign div_ovf_in  = ((f3_in == OpDiv) || (f3_in == OpRem)) &&
                         (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);

    // Shared step adder. Multiply: hi += multiplicand when the multiplier LSB is set.
    // Divide: trial-subtract the divisor from the partial remainder shifted left by one.
    logic        is_div_q, add_sub, add_carry;
    logic [32:0] add_a, add_b, add_sum;

    assign is_div_q = f3_q[2];

    always_comb begin
        if (is_div_q) begin
            add_a   = {hi_q, lo_q[31]};
            add_b   = {1'b0, mag_b_q};
            add_sub = 1'b1;
        end else begin
            add_a   = {1'b0, hi_q};
            add_b   = {1'b0, (lo_q[0] ? mag_a_q : 32'd0)};
            add_sub = 1'b0;
        end
    end

    muldiv_addsub u_addsub (
        .a     (add_a),
        .b     (add_b),
        .sub   (add_sub),
        .sum   (add_sum),
        .carry (add_carry)
    );

    // Sign correction applied in FIX.
    logic [63:0] product, prod_fix;
    logic [31:0] quot_fix, rem_fix, fix_result;
    logic        neg_res;

    assign neg_res  = sign_a_q ^ sign_b_q;
    assign product  = {hi_q, lo_q};
    assign prod_fix = neg_res ? -product : product;
    assign quot_fix = neg_res ? -lo_q : lo_q;
    assign rem_fix  = sign_a_q ? -hi_q : hi_q;

    always_comb begin
        unique case (f3_q)
            OpMul:                    fix_result = prod_fix[31:0];
            OpMulh, OpMulhsu, OpMulhu: fix_result = prod_fix[63:32];
            OpDiv, OpDivu:            fix_result = quot_fix;
            default:                  fix_result = rem_fix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    f3_d     = f3_in;
                    sign_a_d = a_neg_in;
                    sign_b_d = b_neg_in;
                    mag_a_d  = mag_a_in;
                    mag_b_d  = mag_b_in;
                    cnt_d    = 5'd0;
                    hi_d     = 32'd0;
                    // Divide keeps the dividend in lo, multiply keeps the multiplier.
                    lo_d     = funct3[2] ? mag_a_in : mag_b_in;
                    if (div_zero_in) begin
                        state_d  = DONE;
                        result_d = funct3[1] ? op_a : 32'hFFFF_FFFF;
                    end else if (div_ovf_in) begin
                        state_d  = DONE;
                        result_d = funct3[1] ? 32'd0 : 32'h8000_0000;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (is_div_q) begin
                    hi_d = add_carry ? add_sum[31:0] : add_a[31:0];
                    lo_d = {lo_q[30:0], add_carry};
                end else begin
                    hi_d = add_sum[32:1];
                    lo_d = {add_sum[0], lo_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = fix_result;
                state_d  = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
        endcase

        if (flush) begin
            state_d  = IDLE;
            cnt_d    = 5'd0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            f3_q     <= OpMul;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            mag_a_q  <= 32'd0;
            mag_b_q  <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit. Expected results and latencies come from a
// behavioural RV32M model and are queued at issue time, popped when a result appears.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_res_q[$];
    int          exp_lat_q[$];

    typedef struct packed {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    muldiv_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] sa, ua, sb, ub, p;
        logic        ovf;
        sa  = {{32{a[31]}}, a};
        ua  = {32'd0, a};
        sb  = {{32{b[31]}}, b};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'b000: begin p = sa * sb; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 :
                           32'($signed(a) / $signed(b));
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Edges counted including the accepting edge.
    function automatic int model_lat(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
        if (f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 34;
    endfunction

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        funct3   = f;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        exp_res_q.push_back(model(f, a, b));
        exp_lat_q.push_back(model_lat(f, a, b));
    endtask

    // Returns at a negedge with out_valid high, or with lat >= 100 on timeout.
    task automatic wait_result(output logic [31:0] res, output int lat);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res = result;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        funct3    = 3'd0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        op_t ops [5];
        logic [31:0] res, er;
        int lat, el;
        ops = '{'{3'b000, 32'd7, 32'hFFFF_FFFD}, '{3'b000, 32'h1234_5678, 32'h9ABC_DEF0},
                '{3'b001, 32'h8000_0000, 32'h7FFF_FFFF}, '{3'b010, 32'hFFFF_0000, 32'h0001_0000},
                '{3'b011, 32'hDEAD_BEEF, 32'hCAFE_BABE}};
        foreach (ops[i]) begin
            issue(ops[i].f, ops[i].a, ops[i].b);
            wait_result(res, lat);
            consume();
            er = exp_res_q.pop_front();
            el = exp_lat_q.pop_front();
            checks++; if (res !== er) begin errors++; $display("FAIL mul_result[%0d]: got %h want %h", i, res, er); end
            checks++; if (lat != el) begin errors++; $display("FAIL mul_latency[%0d]: got %0d want %0d", i, lat, el); end
        end
    endtask

    task automatic test_mulh_all_ones();
        logic [2:0]  fs [3];
        logic [31:0] want [3];
        logic [31:0] res, er;
        int lat, el;
        fs   = '{3'b011, 3'b001, 3'b010};
        want = '{32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF};
        foreach (fs[i]) begin
            issue(fs[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            wait_result(res, lat);
            consume();
            er = exp_res_q.pop_front();
            el = exp_lat_q.pop_front();
            checks++; if (res !== want[i]) begin errors++; $display("FAIL mulh_ones[%0d]: got %h want %h", i, res, want[i]); end
            checks++; if (res !== er) begin errors++; $display("FAIL mulh_model[%0d]: got %h want %h", i, res, er); end
            checks++; if (lat != el) begin errors++; $display("FAIL mulh_latency[%0d]: got %0d want %0d", i, lat, el); end
        end
    endtask

    task automatic test_div();
        op_t ops [8];
        logic [31:0] res, er;
        int lat, el;
        ops = '{'{3'b100, 32'hFFFF_FFF9, 32'd2}, '{3'b110, 32'hFFFF_FFF9, 32'd2},
                '{3'b101, 32'd7, 32'd0}, '{3'b111, 32'd7, 32'd0},
                '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF}, '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF},
                '{3'b100, 32'd100, 32'hFFFF_FFF9}, '{3'b111, 32'hDEAD_BEEF, 32'd1234}};
        foreach (ops[i]) begin
            issue(ops[i].f, ops[i].a, ops[i].b);
            wait_result(res, lat);
            consume();
            er = exp_res_q.pop_front();
            el = exp_lat_q.pop_front();
            checks++; if (res !== er) begin errors++; $display("FAIL div_result[%0d]: got %h want %h", i, res, er); end
            checks++; if (lat != el) begin errors++; $display("FAIL div_latency[%0d]: got %0d want %0d", i, lat, el); end
        end
    endtask

    task automatic test_hold();
        logic [31:0] res, er;
        int lat;
        issue(3'b101, 32'd100, 32'd7);
        wait_result(res, lat);
        er = exp_res_q.pop_front();
        void'(exp_lat_q.pop_front());
        repeat (5) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_out_valid: got %b want 1", out_valid); end
            checks++; if (result !== er) begin errors++; $display("FAIL hold_result: got %h want %h", result, er); end
            checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL hold_busy_ready: got busy=%b in_ready=%b want 1/0", busy, in_ready); end
        end
        consume();
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL hold_release: got in_ready=%b out_valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy);
        end
    endtask

    task automatic test_flush();
        logic [31:0] res, er;
        int lat, el;
        // Flush while idle must block acceptance.
        @(negedge clk);
        funct3 = 3'b000; op_a = 32'd3; op_b = 32'd5; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL flush_idle_accept: got in_ready=%b busy=%b want 1/0", in_ready, busy); end
        // Flush at CALC count 10.
        issue(3'b000, 32'h1234_5678, 32'h9ABC_DEF0);
        void'(exp_res_q.pop_back());
        void'(exp_lat_q.pop_back());
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL flush_calc: got in_ready=%b out_valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy);
        end
        issue(3'b011, 32'hFFFF_FFFF, 32'd3);
        wait_result(res, lat);
        consume();
        er = exp_res_q.pop_front();
        el = exp_lat_q.pop_front();
        checks++; if (res !== er) begin errors++; $display("FAIL flush_next_result: got %h want %h", res, er); end
        checks++; if (lat != el) begin errors++; $display("FAIL flush_next_latency: got %0d want %0d", lat, el); end
        // Flush in DONE beats a pending out_ready=0 hold.
        issue(3'b101, 32'd9, 32'd0);
        void'(exp_res_q.pop_back());
        void'(exp_lat_q.pop_back());
        wait_result(res, lat);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_done: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_reset_mid();
        int seen;
        issue(3'b011, 32'hDEAD_BEEF, 32'h1234_5678);
        void'(exp_res_q.pop_back());
        void'(exp_lat_q.pop_back());
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || result !== 32'd0) begin
            errors++; $display("FAIL reset_mid: got in_ready=%b busy=%b out_valid=%b result=%h want 1/0/0/0", in_ready, busy, out_valid, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL reset_mid_no_valid: got %0d valid cycles want 0", seen); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res, er, a, b;
        logic [2:0]  f;
        int lat, el;
        for (int i = 0; i < 16; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            issue(f, a, b);
            wait_result(res, lat);
            consume();
            er = exp_res_q.pop_front();
            el = exp_lat_q.pop_front();
            checks++; if (res !== er) begin errors++; $display("FAIL b2b_result[%0d] f=%0d a=%h b=%h: got %h want %h", i, f, a, b, res, er); end
            checks++; if (lat != el) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, lat, el); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_mul();
        test_mulh_all_ones();
        test_div();
        test_hold();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
